// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM bus between fetch and data ports, data first.
// Define ARB_TIMEOUT_EN to add a bus-ack watchdog that aborts after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          i_ce,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_stallreq,
  input  logic          d_ce,
  input  logic          d_we,
  input  logic [3:0]    d_sel,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_stallreq,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_sel,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);
  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;
  state_t state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic [3:0] sel_q;
  logic req_q, we_q, err_q, i_done_q, d_done_q, flushed_q;
  logic i_done_d, d_done_d, tmo, fin, ok;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit watchdog counter (1..255)");
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign tmo = state_q != IDLE && !bus_ack && cnt_q == 8'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst || state_q == IDLE) cnt_q <= '0;
    else if (!bus_ack) cnt_q <= cnt_q + 8'd1;
  end
`else
  assign tmo = 1'b0;
`endif
  assign fin = state_q != IDLE && (bus_ack || tmo);
  // a flush seen at grant or at any point while busy drops the result
  assign ok = fin && !flush_i && !flushed_q;
  assign d_done_d = (ok && state_q == D_BUSY) ? 1'b1 : (flush_i || !stall_i) ? 1'b0 : d_done_q;
  assign i_done_d = (ok && state_q == I_BUSY) ? 1'b1 : (flush_i || !stall_i) ? 1'b0 : i_done_q;
  assign d_stallreq = d_ce & ~d_done_q;
  assign i_stallreq = i_ce & ~i_done_q;
  assign bus_req = req_q;
  assign bus_we = we_q;
  assign bus_sel = sel_q;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_err = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      err_q <= tmo;
      if (state_q == IDLE) begin
        if (d_ce && !d_done_q) begin
          state_q <= D_BUSY;
          req_q <= 1'b1;
          addr_q <= d_addr;
          we_q <= d_we;
          sel_q <= d_sel;
          wdata_q <= d_wdata;
          flushed_q <= flush_i;
        end else if (i_ce && !i_done_q) begin
          state_q <= I_BUSY;
          req_q <= 1'b1;
          addr_q <= i_addr;
          we_q <= 1'b0;
          sel_q <= 4'b1111;
          flushed_q <= flush_i;
        end
      end else begin
        flushed_q <= flushed_q | flush_i;
        if (fin) begin
          state_q <= IDLE;
          req_q <= 1'b0;
        end
        if (fin && state_q == D_BUSY && (tmo || !we_q)) d_rdata_q <= tmo ? '0 : bus_rdata;
        if (fin && state_q == I_BUSY) i_rdata_q <= tmo ? '0 : bus_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboarded bench with a behavioural RAM responder.
module tb_mem_bus_arbiter;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst, stall_i, flush_i, i_ce, d_ce, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0] d_sel;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
  logic i_stallreq, d_stallreq, bus_req, bus_we, bus_err;
  logic [3:0] bus_sel;
  logic [31:0] bus_rdata = '0;
  logic bus_ack = 1'b0;
  logic [31:0] mem [logic [31:0]];
  txn_t exp_q[$], obs_q[$];
  txn_t e, o;
  int checks = 0, errors = 0, waits = 0, wcnt = 0;
  logic ram_on = 1'b1, stray_ack = 1'b0;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_stallreq(i_stallreq),
    .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stallreq(d_stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_req && ram_on && wcnt == waits) begin
      bus_ack = 1'b1;
      bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
      obs_q.push_back('{bus_addr, bus_we, bus_sel, bus_wdata});
      if (bus_we) mem[bus_addr] = bus_wdata;
      wcnt = 0;
    end else begin
      bus_ack = stray_ack;
      wcnt = bus_req ? wcnt + 1 : 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall_i = 0; flush_i = 0; i_ce = 0; d_ce = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0;
    tick; tick;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus_req); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_err); end
    checks++; if ({bus_we, bus_sel, bus_addr, bus_wdata} !== '0) begin errors++; $display("FAIL rst_bus: got %b %h %h %h want 0", bus_we, bus_sel, bus_addr, bus_wdata); end
    checks++; if ({i_rdata, d_rdata} !== '0) begin errors++; $display("FAIL rst_rdata: got %h %h want 0", i_rdata, d_rdata); end
    d_ce = 1;
    #1;
    checks++; if (d_stallreq !== 1'b1) begin errors++; $display("FAIL rst_stallreq: got %b want 1", d_stallreq); end
    d_ce = 0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_single_load;
    mem[32'h100] = 32'hDEADBEEF; waits = 0;
    d_ce = 1; d_we = 0; d_sel = 4'b1111; d_addr = 32'h100; d_wdata = 32'h0;
    exp_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
    tick;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin errors++; $display("FAIL load_c1: got req=%b addr=%h want 1 100", bus_req, bus_addr); end
    checks++; if (d_stallreq !== 1'b1) begin errors++; $display("FAIL load_stall_c1: got %b want 1", d_stallreq); end
    tick;
    checks++; if (d_stallreq !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_c2: got stall=%b rdata=%h want 0 deadbeef", d_stallreq, d_rdata); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL load_req_c2: got %b want 0", bus_req); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL load_sb: got no bus cycle want 1"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front(); if (o !== e) begin errors++; $display("FAIL load_sb: got %h want %h", o, e); end end
    d_ce = 0;
    tick;
  endtask

  task automatic test_store;
    d_ce = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h104; d_wdata = 32'h0000ABCD;
    exp_q.push_back('{32'h104, 1'b1, 4'b0011, 32'h0000ABCD});
    tick;
    checks++; if (bus_we !== 1'b1 || bus_sel !== 4'b0011 || bus_wdata !== 32'h0000ABCD) begin errors++; $display("FAIL store_bus: got we=%b sel=%b wdata=%h want 1 0011 0000abcd", bus_we, bus_sel, bus_wdata); end
    tick;
    checks++; if (d_stallreq !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_c2: got stall=%b rdata=%h want 0 deadbeef", d_stallreq, d_rdata); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL store_sb: got no bus cycle want 1"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front(); if (o !== e) begin errors++; $display("FAIL store_sb: got %h want %h", o, e); end end
    d_ce = 0; d_we = 0;
    tick;
  endtask

  task automatic test_conflict;
    mem[32'h200] = 32'h11111111; mem[32'h300] = 32'h22222222;
    d_ce = 1; d_we = 0; d_sel = 4'b1111; d_addr = 32'h200; d_wdata = 32'h5A5A5A5A;
    i_ce = 1; i_addr = 32'h300;
    exp_q.push_back('{32'h200, 1'b0, 4'b1111, 32'h5A5A5A5A});
    exp_q.push_back('{32'h300, 1'b0, 4'b1111, 32'h5A5A5A5A});
    tick;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h200) begin errors++; $display("FAIL conf_d_first: got req=%b addr=%h want 1 200", bus_req, bus_addr); end
    tick;
    checks++; if (d_stallreq !== 1'b0 || d_rdata !== 32'h11111111 || i_stallreq !== 1'b1) begin errors++; $display("FAIL conf_c2: got dstall=%b rdata=%h istall=%b want 0 11111111 1", d_stallreq, d_rdata, i_stallreq); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL conf_idle: got %b want 0", bus_req); end
    d_ce = 0;
    tick;
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h300 || bus_sel !== 4'b1111 || bus_we !== 1'b0) begin errors++; $display("FAIL conf_i_second: got req=%b addr=%h sel=%b we=%b want 1 300 1111 0", bus_req, bus_addr, bus_sel, bus_we); end
    checks++; if (i_stallreq !== 1'b1) begin errors++; $display("FAIL conf_istall_c3: got %b want 1", i_stallreq); end
    tick;
    checks++; if (i_stallreq !== 1'b0 || i_rdata !== 32'h22222222) begin errors++; $display("FAIL conf_c4: got istall=%b rdata=%h want 0 22222222", i_stallreq, i_rdata); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL conf_sb%0d: got no bus cycle want 1", k); end
      else begin o = obs_q.pop_front(); e = exp_q.pop_front(); if (o !== e) begin errors++; $display("FAIL conf_sb%0d: got %h want %h", k, o, e); end end
    end
    i_ce = 0;
    tick;
  endtask

  task automatic test_hold_stall;
    mem[32'h400] = 32'h24010005;
    i_ce = 1; i_addr = 32'h400; stall_i = 1;
    exp_q.push_back('{32'h400, 1'b0, 4'b1111, 32'h5A5A5A5A});
    tick; tick;
    for (int k = 0; k < 3; k++) begin
      checks++; if (i_stallreq !== 1'b0 || i_rdata !== 32'h24010005 || bus_req !== 1'b0) begin errors++; $display("FAIL hold_%0d: got istall=%b rdata=%h req=%b want 0 24010005 0", k, i_stallreq, i_rdata, bus_req); end
      if (k == 2) stall_i = 0;
      tick;
    end
    checks++; if (i_stallreq !== 1'b1) begin errors++; $display("FAIL hold_clear: got istall=%b want 1", i_stallreq); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL hold_sb: got no bus cycle want 1"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front(); if (o !== e) begin errors++; $display("FAIL hold_sb: got %h want %h", o, e); end end
    i_ce = 0;
    tick;
  endtask

  task automatic test_flush;
    mem[32'h500] = 32'hCAFEF00D; waits = 3;
    d_ce = 1; d_we = 0; d_sel = 4'b1111; d_addr = 32'h500; d_wdata = 32'h0;
    exp_q.push_back('{32'h500, 1'b0, 4'b1111, 32'h0});
    tick;
    flush_i = 1;
    tick;
    flush_i = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus_req !== 1'b1 || d_stallreq !== 1'b1) begin errors++; $display("FAIL flush_busy%0d: got req=%b dstall=%b want 1 1", k, bus_req, d_stallreq); end
      tick;
    end
    checks++; if (bus_req !== 1'b0 || d_stallreq !== 1'b1) begin errors++; $display("FAIL flush_end: got req=%b dstall=%b want 0 1", bus_req, d_stallreq); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL flush_sb: got no bus cycle want 1"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front(); if (o !== e) begin errors++; $display("FAIL flush_sb: got %h want %h", o, e); end end
    d_ce = 0; waits = 0;
    tick;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    ram_on = 0;
    d_ce = 1; d_we = 0; d_sel = 4'b1111; d_addr = 32'h700;
    tick; tick; tick; tick;
    checks++; if (bus_req !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL tmo_c4: got req=%b err=%b want 1 0", bus_req, bus_err); end
    tick;
    checks++; if (bus_err !== 1'b1 || bus_req !== 1'b0 || d_rdata !== 32'h0 || d_stallreq !== 1'b0) begin errors++; $display("FAIL tmo_c5: got err=%b req=%b rdata=%h dstall=%b want 1 0 0 0", bus_err, bus_req, d_rdata, d_stallreq); end
    d_ce = 0;
    tick;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b want 0", bus_err); end
    ram_on = 1;
  endtask
`endif

  task automatic test_reset_mid_busy;
    ram_on = 0;
    i_ce = 1; i_addr = 32'h600;
    tick;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmb_busy: got %b want 1", bus_req); end
    rst = 0; i_ce = 0;
    tick;
    checks++; if ({bus_req, bus_we, bus_err, bus_sel, bus_addr, bus_wdata, i_rdata, d_rdata} !== '0) begin errors++; $display("FAIL rmb_outs: got req=%b addr=%h sel=%b rdata=%h/%h want all 0", bus_req, bus_addr, bus_sel, i_rdata, d_rdata); end
    rst = 1; stray_ack = 1; ram_on = 1;
    bus_rdata = 32'hBAD0BAD0;
    tick; tick;
    stray_ack = 0;
    checks++; if (bus_req !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rmb_stray: got req=%b rdata=%h/%h want 0 0 0", bus_req, i_rdata, d_rdata); end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_load;
    test_store;
    test_conflict;
    test_hold_stall;
    test_flush;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_busy;
    checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported RAM bus between the instruction-fetch port and the mem-stage data port.
- Each transaction is granted and sequenced through an IDLE/BUSY state machine, with fixed data-over-instruction priority.
- Raises a per-port stall request until that port's transfer completes.
- Returned read data is held in a per-port buffer until the global pipeline stall drops.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, bus-ack watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- stall_i  in  1  global pipeline stall from ctrl.
- flush_i  in  1  pipeline flush; discards pending and returned results.
- i_ce  in  1  instruction fetch request.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched word (buffered).
- i_stallreq  out  1  fetch not yet complete.
- d_ce  in  1  data access request.
- d_we  in  1  data write enable.
- d_sel  in  4  byte lanes.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data (buffered).
- d_stallreq  out  1  data access not yet complete.
- bus_req  out  1  RAM bus cycle active.
- bus_we  out  1  RAM write.
- bus_sel  out  4  RAM byte lanes.
- bus_addr  out  AW  RAM address.
- bus_wdata  out  DW  RAM write data.
- bus_rdata  in  DW  RAM read data.
- bus_ack  in  1  RAM transfer complete.
- bus_err  out  1  watchdog abort pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State = IDLE.
  - bus_req, bus_we, bus_err = 0; bus_sel = 0; bus_addr, bus_wdata = 0.
  - i_rdata, d_rdata = 0; i_done, d_done = 0.
  - Reset mid-transaction abandons the bus cycle immediately; any later bus_ack is ignored.
- Stall requests (combinational):
  - d_stallreq = d_ce & ~d_done.
  - i_stallreq = i_ce & ~i_done.
- IDLE:
  - If d_ce & ~d_done: latch d_addr/d_we/d_sel/d_wdata onto the bus registers, then go to D_BUSY.
  - Else if i_ce & ~i_done: latch i_addr, bus_we=0, bus_sel=4'b1111, then go to I_BUSY.
  - Else stay in IDLE; bus_req=0.
- D_BUSY / I_BUSY:
  - bus_req=1; bus outputs are frozen, and requester input changes are ignored.
  - On bus_ack:
    - Load d_rdata (D_BUSY, reads only; writes leave d_rdata unchanged) or i_rdata (I_BUSY) from bus_rdata.
    - Set d_done or i_done, unless flush_i is high or was seen during the busy period.
    - Drop bus_req next cycle and return to IDLE.
  - bus_ack while in IDLE is ignored.
- Latency with zero-wait RAM:
  - Request visible in cycle 0, bus_req high in cycle 1, ack in cycle 1.
  - Stallreq drops and buffered data is valid from cycle 2.
  - Back-to-back: the next grant decision is made in the IDLE cycle (cycle 2), so bus_req for a second transfer is high in cycle 3.
- Done clearing:
  - x_done clears on the first edge where stall_i==0, because the pipeline has consumed the result.
  - While stall_i==1, done and buffered data hold. This covers the case where one port finished while the other is still stalling.
- Flush:
  - flush_i==1 clears both done flags.
  - A busy transaction completes on the bus (no abort) but its result is dropped; no done is set.
- Simultaneous requests: data wins. Fetch is granted in the IDLE cycle after the data transfer completes, provided its done is clear.
- A request dropped (ce=0) while BUSY still completes on the bus; the result is buffered, and done is only visible via stallreq when ce is reasserted.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without bus_ack.
  - On reaching TIMEOUT: pulse bus_err for 1 cycle, drop bus_req, go to IDLE, load the granted port's rdata with 0 and set its done (so the pipeline does not hang).
  - bus_ack in the same cycle as timeout wins (normal completion, no bus_err).
- When undefined: no counter; bus_err is constant 0; BUSY waits indefinitely.

Test Plan:
- Single load:
  - Stimulus: d_ce=1, d_we=0, d_addr=0x100, RAM acks in cycle 1 with 0xDEADBEEF.
  - Required: bus_req high in cycle 1, d_stallreq low and d_rdata=0xDEADBEEF in cycle 2.
- Conflict:
  - Stimulus: i_ce and d_ce both high in the same cycle, zero-wait RAM.
  - Required: data cycle at d_addr first, fetch cycle at i_addr second with bus_sel=4'b1111; i_stallreq stays high until its own ack+1.
- Hold under stall:
  - Stimulus: fetch completes with 0x24010005 while stall_i=1 for 3 more cycles.
  - Required: i_stallreq stays 0 and i_rdata holds 0x24010005; i_done clears after stall_i drops.
- Flush mid-transfer:
  - Stimulus: assert flush_i during D_BUSY with a 3-wait-state ack.
  - Required: bus cycle completes, d_done stays 0, d_stallreq reasserts if d_ce is still high.
- Store:
  - Stimulus: d_we=1, d_sel=4'b0011, d_wdata=0x0000ABCD.
  - Required: bus_we=1, bus_sel=4'b0011, bus_wdata=0x0000ABCD; d_rdata unchanged.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: no bus_ack.
  - Required: bus_err pulses after 4 BUSY cycles, d_rdata=0, d_stallreq drops; reset asserted mid-BUSY returns all outputs to 0 the next edge.
